// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter: the driver (master) owns the
// count controls, the counter (slave) owns count, terminal count, wrap flag and display.
interface param_updown_counter_if #(
    parameter int WIDTH = 8
);
    localparam int HEX_W = 7 * ((WIDTH + 3) / 4);

    logic             enable;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic [HEX_W-1:0] hex;

    modport master (
        output enable, up, load, data,
        input  q, tc, wrap, hex
    );

    modport slave (
        input  enable, up, load, data,
        output q, tc, wrap, hex
    );
endinterface

// File: rtl/param_updown_counter.sv
// Modulo-(MAX_COUNT+1) up/down counter with clamped parallel load, cascade TC and sticky wrap.
// Define PARAM_COUNTER_HEX_EN to drive the active-low 7-segment digits; otherwise they stay blank.
module param_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255
) (
    input logic                  clk,
    input logic                  rst_n,
    param_updown_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] load_val;
    logic             at_max;
    logic             at_zero;
    logic             tc_w;

    assign at_max   = (q_r == MAX_Q);
    assign at_zero  = (q_r == '0);
    assign load_val = (bus.data > MAX_Q) ? MAX_Q : bus.data;

    // A wrap happens exactly when TC is high and no load overrides the edge.
    assign tc_w = bus.enable & ((bus.up & at_max) | (~bus.up & at_zero));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else if (bus.load) begin
            q_r    <= load_val;
            wrap_r <= 1'b0;
        end else if (bus.enable) begin
            if (bus.up) begin
                q_r <= at_max ? '0 : q_r + 1'b1;
            end else begin
                q_r <= at_zero ? MAX_Q : q_r - 1'b1;
            end
            if (tc_w) begin
                wrap_r <= 1'b1;
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;
    assign bus.tc   = tc_w;

`ifdef PARAM_COUNTER_HEX_EN
    localparam int NDIG = (WIDTH + 3) / 4;

    logic [4*NDIG-1:0] q_pad;
    assign q_pad = (4*NDIG)'(q_r);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        assign bus.hex[7*i +: 7] = seg7(q_pad[4*i +: 4]);
    end
`else
    assign bus.hex = '1;
`endif
endmodule
